block_looper: RTL
=================

Name: block_looper

Overview:
- Upstream neighbour of the accumulation block looper: walks the global block grid and issues one block offset vector per work block on a rdy/ack port.
- Also tracks blocks in flight using the downstream blkdone pulses, throttles issue, and signals grid completion once all blocks have drained.

Parameters:
- VDIM, 6, number of grid dimensions; index VDIM-1 is innermost.
- WBW, 16, width of each offset and step lane.
- MAX_INFLIGHT, 4, maximum number of issued blocks without a blkdone; must be at least 1.
- IF_BW, $clog2(MAX_INFLIGHT+1), width of the in-flight counter (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- cfg_rdy  in  1  grid config valid.
- cfg_ack  out  1  config accepted (single-cycle pulse).
- i_bgrid_step  in  VDIM*WBW  per-dim block step; lane i is bits [i*WBW +: WBW].
- i_bgrid_end  in  VDIM*WBW  per-dim exclusive end.
- bofs_rdy  out  1  block offset valid.
- bofs_ack  in  1  downstream accepts o_bofs.
- o_bofs  out  VDIM*WBW  current block offset.
- blkdone_dval  in  1  one block fully processed downstream.
- done_rdy  out  1  grid complete.
- done_ack  in  1  completion consumed.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE.
- Reset values:
  - state = IDLE; cfg_ack = 0; bofs_rdy = 0; done_rdy = 0.
  - o_bofs = 0; in-flight count = 0; latched step and end = 0.
- IDLE:
  - cfg_ack = cfg_rdy (combinational). On that cycle latch step and end and clear o_bofs to 0.
  - If any end lane is 0, or any step lane is 0, go to DONE (empty grid, zero blocks issued). Otherwise go to RUN.
  - First bofs_rdy appears the cycle after cfg_ack.
- RUN:
  - bofs_rdy = (inflight < MAX_INFLIGHT).
  - bofs_ack is legal only while bofs_rdy is high. o_bofs holds stable while bofs_rdy && !bofs_ack.
- Advance on bofs_ack: odometer increment from dim VDIM-1 down to 0.
  - Per dim: nxt = o_bofs[i] + step[i], computed in WBW+1 bits.
  - If nxt >= end[i] (unsigned): the lane wraps to 0 and carries to dim i-1. Otherwise the lane takes nxt and the carry stops.
  - A carry out of dim 0 means the ack'd block was the last one: go to DRAIN, with o_bofs = 0.
- In-flight counter:
  - Increments on bofs_ack, decrements on blkdone_dval; both in the same cycle leave it unchanged.
  - blkdone_dval with count 0 is ignored; the counter saturates at 0.
  - blkdone_dval is accepted in every state, but has effect only with count > 0.
- DRAIN: bofs_rdy = 0. When the count reaches 0 (including a decrement that cycle), go to DONE on the next cycle.
- DONE: done_rdy = 1. On done_ack go to IDLE. cfg_ack cannot be asserted in the same cycle as done_ack.
- Throughput: one block per cycle while not throttled. The ack'd offset value changes on the cycle after ack.
- Config is ignored outside IDLE; cfg_ack stays 0.
- i_rst mid-operation: all state returns to reset values on the next edge. Pending blocks are forgotten and no done_rdy is produced.

Test Plan:
- Basic 2-D walk:
  - Stimulus: VDIM=6; dims 0..3 end=1, step=1; dim4 end=4, step=2; dim5 end=6, step=3; downstream always acks; blkdone echoed 3 cycles after each ack.
  - Required: o_bofs (dim4, dim5) sequence is (0,0),(0,3),(2,0),(2,3); exactly 4 acks; done_rdy after the 4th blkdone.
- Throttle:
  - Stimulus: MAX_INFLIGHT=4; 8-block grid; blkdone withheld.
  - Required: exactly 4 acks, then bofs_rdy=0. One blkdone pulse leads to exactly one more ack.
- Simultaneous ack and blkdone:
  - Stimulus: inflight=3; bofs_ack and blkdone_dval in the same cycle.
  - Required: count stays 3; bofs_rdy stays 1.
- Non-dividing end:
  - Stimulus: dim5 end=5, step=2.
  - Required: offsets 0,2,4, then wrap. nxt=6 >= 5 triggers the carry; 3 blocks per outer step.
- Empty grid:
  - Stimulus: dim2 end=0.
  - Required: cfg_ack, then done_rdy on the next cycle with zero bofs_rdy cycles; done_ack returns to IDLE.
- Reset mid-run and stray blkdone:
  - Stimulus: i_rst high during RUN with inflight=2; afterwards a stray blkdone_dval in IDLE.
  - Required: all outputs 0 after the reset edge; count stays 0; a new cfg is accepted normally.

Source files
------------

// File: rtl/block_looper_if.sv
// Handshake bundle for block_looper: grid config in, block offsets out,
// blkdone feedback and grid-complete handshake.
interface block_looper_if #(
   parameter int VDIM = 6,
   parameter int WBW  = 16
);
   logic                cfg_rdy;
   logic                cfg_ack;
   logic [VDIM*WBW-1:0] i_bgrid_step;
   logic [VDIM*WBW-1:0] i_bgrid_end;
   logic                bofs_rdy;
   logic                bofs_ack;
   logic [VDIM*WBW-1:0] o_bofs;
   logic                blkdone_dval;
   logic                done_rdy;
   logic                done_ack;

   modport master (
      output cfg_rdy, i_bgrid_step, i_bgrid_end, bofs_ack, blkdone_dval, done_ack,
      input  cfg_ack, bofs_rdy, o_bofs, done_rdy
   );

   modport slave (
      input  cfg_rdy, i_bgrid_step, i_bgrid_end, bofs_ack, blkdone_dval, done_ack,
      output cfg_ack, bofs_rdy, o_bofs, done_rdy
   );
endinterface

// File: rtl/block_looper.sv
// Walks the block grid as an odometer (innermost dim VDIM-1), issuing one
// offset per handshake, throttled by blocks in flight, then drains to done.
module block_looper #(
   parameter int VDIM         = 6,
   parameter int WBW          = 16,
   parameter int MAX_INFLIGHT = 4,
   parameter int IF_BW        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic           i_clk,
   input  logic           i_rst,
   block_looper_if.slave  bl
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [VDIM-1:0][WBW-1:0] step_q, end_q, bofs_q, bofs_nxt;
   logic [VDIM-1:0][WBW-1:0] cfg_step, cfg_end;
   logic [IF_BW-1:0]        inflight, inflight_nxt;
   logic [WBW:0]            sum;
   logic                    carry, last, empty, inc, dec, room;
   logic                    cfg_ack, bofs_rdy, done_rdy;

   assign cfg_step = bl.i_bgrid_step;
   assign cfg_end  = bl.i_bgrid_end;

   // Any zero lane means the grid holds no blocks at all.
   always_comb begin
      empty = 1'b0;
      for (int i = 0; i < VDIM; i++)
         if (cfg_step[i] == '0 || cfg_end[i] == '0) empty = 1'b1;
   end

   // Odometer step; the extra sum bit keeps lanes near the top of the range
   // from wrapping before the end compare.
   always_comb begin
      bofs_nxt = bofs_q;
      carry    = 1'b1;
      sum      = '0;
      for (int i = VDIM - 1; i >= 0; i--) begin
         sum = {1'b0, bofs_q[i]} + {1'b0, step_q[i]};
         if (carry) begin
            if (sum >= {1'b0, end_q[i]}) begin
               bofs_nxt[i] = '0;
            end else begin
               bofs_nxt[i] = sum[WBW-1:0];
               carry       = 1'b0;
            end
         end
      end
      last = carry;
   end

   assign room = (inflight < IF_BW'(MAX_INFLIGHT));
   assign inc  = (state == RUN) && room && bl.bofs_ack;
   assign dec  = bl.blkdone_dval && (inflight != '0);

   always_comb begin
      inflight_nxt = inflight;
      case ({inc, dec})
         2'b10:   inflight_nxt = inflight + IF_BW'(1);
         2'b01:   inflight_nxt = inflight - IF_BW'(1);
         default: inflight_nxt = inflight;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cfg_ack   = 1'b0;
      bofs_rdy  = 1'b0;
      done_rdy  = 1'b0;
      case (state)
         IDLE: begin
            cfg_ack = bl.cfg_rdy;
            if (bl.cfg_rdy) state_nxt = empty ? DONE : RUN;
         end
         RUN: begin
            bofs_rdy = room;
            if (inc && last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (inflight_nxt == '0) state_nxt = DONE;
         end
         DONE: begin
            done_rdy = 1'b1;
            if (bl.done_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         step_q   <= '0;
         end_q    <= '0;
         bofs_q   <= '0;
         inflight <= '0;
      end else begin
         if (cfg_ack) begin
            step_q <= cfg_step;
            end_q  <= cfg_end;
            bofs_q <= '0;
         end else if (inc) begin
            bofs_q <= bofs_nxt;
         end
         inflight <= inflight_nxt;
      end
   end

   assign bl.cfg_ack  = cfg_ack;
   assign bl.bofs_rdy = bofs_rdy;
   assign bl.done_rdy = done_rdy;
   assign bl.o_bofs   = bofs_q;
endmodule
